// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared definitions for the junction phase controller: phase encoding and
// the BCD helper used for the 7-segment countdown.
package traffic_phase_ctrl_pkg;

  // Phase encoding as seen on the phase output port.
  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_AMBER  = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  // Two-digit BCD of a value in 0..99: [7:4] tens, [3:0] units.
  function automatic logic [7:0] to_bcd2(input logic [6:0] value);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(value / 7'd10);
    units = 4'(value % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_road_arbiter.sv
// Wrap-around priority search: returns the first set request bit found when
// scanning from i_start upward, wrapping modulo NUM_ROADS.
module rr_road_arbiter #(
  parameter int NUM_ROADS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_ROADS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_start,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  // Scan from farthest to nearest so the nearest set bit is written last and wins.
  always_comb begin
    int w_pos;
    w_pos   = 0;
    o_idx   = i_start;
    o_valid = 1'b0;
    for (int k = NUM_ROADS - 1; k >= 0; k--) begin
      w_pos   = (int'(i_start) + k) % NUM_ROADS;
      o_valid = o_valid | i_req[w_pos];
      o_idx   = i_req[w_pos] ? IDX_W'(w_pos) : o_idx;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-road junction phase controller. Each granted road runs GREEN -> AMBER ->
// ALL_RED; the next road is chosen at the end of ALL_RED with emergency
// requests first, then load requests round-robin, then plain round-robin.
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int NUM_ROADS     = 4,
  parameter int IDX_W         = 2,
  parameter int GREEN_CYCLES  = 16,
  parameter int AMBER_CYCLES  = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int CNT_W         = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_ROADS-1:0] emer_req,
  input  logic [NUM_ROADS-1:0] load_req,
  output logic [NUM_ROADS-1:0] green,
  output logic [NUM_ROADS-1:0] amber,
  output logic [NUM_ROADS-1:0] red,
  output logic [IDX_W-1:0]     active_road,
  output logic [1:0]           phase,
  output logic [CNT_W-1:0]     countdown,
  output logic [7:0]           count_bcd,
  output logic                 emer_ack
);

  localparam logic [CNT_W-1:0]     L_GREEN  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]     L_AMBER  = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0]     L_ALLRED = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_ROADS - 1);
  localparam logic [NUM_ROADS-1:0] ONE_HOT0 = {{(NUM_ROADS-1){1'b0}}, 1'b1};

  phase_e                r_phase;
  logic [CNT_W-1:0]      r_countdown;
  logic [IDX_W-1:0]      r_active_road;
  logic [NUM_ROADS-1:0]  r_green;
  logic [NUM_ROADS-1:0]  r_amber;
  logic [NUM_ROADS-1:0]  r_red;
  logic                  r_emer_ack;
  logic [7:0]            r_count_bcd;

  phase_e                w_nxt_phase;
  logic [CNT_W-1:0]      w_nxt_count;
  logic [IDX_W-1:0]      w_nxt_road;
  logic                  w_nxt_ack;
  logic [NUM_ROADS-1:0]  w_nxt_green;
  logic [NUM_ROADS-1:0]  w_nxt_amber;
  logic [NUM_ROADS-1:0]  w_nxt_red;
  logic [NUM_ROADS-1:0]  w_nxt_mask;
  logic [NUM_ROADS-1:0]  w_road_mask;
  logic                  w_own_emer;
  logic                  w_other_emer;
  logic                  w_cnt_zero;
  logic [IDX_W-1:0]      w_road_inc;
  logic [IDX_W-1:0]      w_emer_idx;
  logic                  w_emer_vld;
  logic [IDX_W-1:0]      w_load_idx;
  logic                  w_load_vld;

  assign w_road_mask  = ONE_HOT0 << r_active_road;
  assign w_own_emer   = |(emer_req & w_road_mask);
  assign w_other_emer = |(emer_req & ~w_road_mask);
  assign w_cnt_zero   = (r_countdown == {CNT_W{1'b0}});
  assign w_road_inc   = (r_active_road == IDX_LAST) ? {IDX_W{1'b0}}
                                                    : r_active_road + IDX_W'(1);

  // Emergency grants go to the lowest-index requester, so the scan starts at 0.
  rr_road_arbiter #(.NUM_ROADS(NUM_ROADS), .IDX_W(IDX_W)) u_emer_arb (
    .i_req   (emer_req),
    .i_start ({IDX_W{1'b0}}),
    .o_idx   (w_emer_idx),
    .o_valid (w_emer_vld)
  );

  // Load grants rotate: the scan starts at the road after the current owner.
  rr_road_arbiter #(.NUM_ROADS(NUM_ROADS), .IDX_W(IDX_W)) u_load_arb (
    .i_req   (load_req),
    .i_start (w_road_inc),
    .o_idx   (w_load_idx),
    .o_valid (w_load_vld)
  );

  // Next phase, countdown, owning road and emergency acknowledge.
  always_comb begin
    w_nxt_phase = r_phase;
    w_nxt_count = r_countdown - CNT_W'(1);
    w_nxt_road  = r_active_road;
    w_nxt_ack   = 1'b0;
    case (r_phase)
      PH_GREEN: begin
        if (w_own_emer) begin
          // Own-road emergency keeps the green and beats preemption.
          w_nxt_count = L_GREEN;
        end else if (w_cnt_zero || w_other_emer) begin
          w_nxt_phase = PH_AMBER;
          w_nxt_count = L_AMBER;
        end else begin
          w_nxt_count = r_countdown - CNT_W'(1);
        end
      end
      PH_AMBER: begin
        if (w_cnt_zero) begin
          w_nxt_phase = PH_ALLRED;
          w_nxt_count = L_ALLRED;
        end else begin
          w_nxt_count = r_countdown - CNT_W'(1);
        end
      end
      PH_ALLRED: begin
        if (w_cnt_zero) begin
          w_nxt_phase = PH_GREEN;
          w_nxt_count = L_GREEN;
          if (w_emer_vld) begin
            w_nxt_road = w_emer_idx;
            w_nxt_ack  = 1'b1;
          end else if (w_load_vld) begin
            w_nxt_road = w_load_idx;
          end else begin
            w_nxt_road = w_road_inc;
          end
        end else begin
          w_nxt_count = r_countdown - CNT_W'(1);
        end
      end
      default: begin
        // Unused encoding: fall back to a safe clearance phase.
        w_nxt_phase = PH_ALLRED;
        w_nxt_count = L_ALLRED;
      end
    endcase
  end

  // Lamp pattern for the upcoming phase; every road not owning it is red.
  always_comb begin
    w_nxt_mask  = ONE_HOT0 << w_nxt_road;
    w_nxt_green = {NUM_ROADS{1'b0}};
    w_nxt_amber = {NUM_ROADS{1'b0}};
    w_nxt_red   = {NUM_ROADS{1'b1}};
    case (w_nxt_phase)
      PH_GREEN: begin
        w_nxt_green = w_nxt_mask;
        w_nxt_red   = ~w_nxt_mask;
      end
      PH_AMBER: begin
        w_nxt_amber = w_nxt_mask;
        w_nxt_red   = ~w_nxt_mask;
      end
      default: begin
        w_nxt_red   = {NUM_ROADS{1'b1}};
      end
    endcase
  end

  // State and output registers; reset lands in the all-red clearance phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= PH_ALLRED;
      r_countdown   <= L_ALLRED;
      r_active_road <= IDX_LAST;
      r_green       <= {NUM_ROADS{1'b0}};
      r_amber       <= {NUM_ROADS{1'b0}};
      r_red         <= {NUM_ROADS{1'b1}};
      r_emer_ack    <= 1'b0;
      r_count_bcd   <= to_bcd2(7'(L_ALLRED));
    end else begin
      r_phase       <= w_nxt_phase;
      r_countdown   <= w_nxt_count;
      r_active_road <= w_nxt_road;
      r_green       <= w_nxt_green;
      r_amber       <= w_nxt_amber;
      r_red         <= w_nxt_red;
      r_emer_ack    <= w_nxt_ack;
      r_count_bcd   <= to_bcd2(7'(w_nxt_count));
    end
  end

  assign phase       = r_phase;
  assign countdown   = r_countdown;
  assign active_road = r_active_road;
  assign green       = r_green;
  assign amber       = r_amber;
  assign red         = r_red;
  assign emer_ack    = r_emer_ack;
  assign count_bcd   = r_count_bcd;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed request sequences, expected phase
// transitions queued up front and checked by a separate monitor.
module tb_traffic_phase_ctrl;
  import traffic_phase_ctrl_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] emer_req = 4'b0000;
  logic [3:0] load_req = 4'b0000;
  logic [3:0] green, amber, red;
  logic [1:0] active_road;
  logic [1:0] phase;
  logic [5:0] countdown;
  logic [7:0] count_bcd;
  logic       emer_ack;

  traffic_phase_ctrl dut (
    .clk(clk), .reset(reset), .emer_req(emer_req), .load_req(load_req),
    .green(green), .amber(amber), .red(red), .active_road(active_road),
    .phase(phase), .countdown(countdown), .count_bcd(count_bcd),
    .emer_ack(emer_ack)
  );

  always #5 clk = ~clk;

  // Edges since reset was last released.
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         c;
    logic [1:0] ph;
    int         road;
    logic       ack;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [1:0] ph, input int road, input logic ack);
    ev_t e;
    e.c = c; e.ph = ph; e.road = road; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic int len_of(input logic [1:0] ph);
    if (ph == PH_GREEN)      return 16;
    else if (ph == PH_AMBER) return 4;
    else                     return 2;
  endfunction

  // Monitor: lamp/BCD checks every cycle, scoreboard pop on each phase change.
  initial begin
    logic [1:0] prev_ph;
    logic [3:0] m, eg, ea;
    ev_t        e;
    int         bad, c;
    prev_ph = PH_ALLRED;
    forever begin
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < N; i++)
        if ((int'(green[i]) + int'(amber[i]) + int'(red[i])) != 1) bad++;
      chk("lamp_onehot", bad, 0);
      m  = 4'b0001 << active_road;
      eg = (phase == PH_GREEN) ? m : 4'b0000;
      ea = (phase == PH_AMBER) ? m : 4'b0000;
      chk("lamp_pattern", {green, amber, red}, {eg, ea, ~(eg | ea)});
      c = int'(countdown);
      chk("count_bcd", count_bcd, ((c / 10) << 4) | (c % 10));
      if (reset) begin
        prev_ph = phase;
      end else if (phase != prev_ph) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_transition: got phase %0d expected none (cyc %0d)", phase, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ev_cycle", cyc, e.c);
          chk("ev_phase", phase, e.ph);
          chk("ev_road", active_road, e.road);
          chk("ev_ack", emer_ack, e.ack);
          chk("ev_count", countdown, len_of(e.ph) - 1);
        end
        prev_ph = phase;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    // Reset state.
    @(negedge clk);
    chk("rst_phase", phase, PH_ALLRED);
    chk("rst_count", countdown, 1);
    chk("rst_road", active_road, 3);
    chk("rst_red", red, 4'b1111);
    chk("rst_green", green, 4'b0000);
    chk("rst_amber", amber, 4'b0000);
    chk("rst_ack", emer_ack, 0);
    chk("rst_bcd", count_bcd, 8'h01);

    // Plain rotation 0,1,2,3 then back to 0; 22 cycles per road.
    for (int r = 0; r < 4; r++) begin
      push_ev(2 + 22 * r,      PH_GREEN,  r, 1'b0);
      push_ev(2 + 22 * r + 16, PH_AMBER,  r, 1'b0);
      push_ev(2 + 22 * r + 20, PH_ALLRED, r, 1'b0);
    end
    push_ev(90, PH_GREEN, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Road 0 green at countdown 10: one-cycle preemption from road 2.
    wait_cyc(95);
    chk("t2_count10", countdown, 10);
    push_ev(96,  PH_AMBER,  0, 1'b0);
    push_ev(100, PH_ALLRED, 0, 1'b0);
    push_ev(102, PH_GREEN,  2, 1'b1);
    emer_req = 4'b0100;
    wait_cyc(96);
    emer_req = 4'b0000;
    wait_cyc(101);
    emer_req = 4'b0100;
    wait_cyc(102);
    emer_req = 4'b0000;
    wait_cyc(103);
    chk("t2_ack_pulse", emer_ack, 0);

    // Load request steers selection to road 1, then an own-road hold.
    push_ev(118, PH_AMBER,  2, 1'b0);
    push_ev(122, PH_ALLRED, 2, 1'b0);
    push_ev(124, PH_GREEN,  1, 1'b0);
    push_ev(180, PH_AMBER,  1, 1'b0);
    push_ev(184, PH_ALLRED, 1, 1'b0);
    wait_cyc(122);
    load_req = 4'b0010;
    wait_cyc(124);
    load_req = 4'b0000;
    emer_req = 4'b0010;
    for (int k = 125; k <= 164; k++) begin
      wait_cyc(k);
      chk("t3_hold_count", countdown, 15);
      chk("t3_hold_green", green, 4'b0010);
    end
    emer_req = 4'b0000;
    wait_cyc(179);
    chk("t3_last_green", countdown, 0);

    // Load round-robin with wrap: 3, then 0, 2, 0 under load 0101.
    wait_cyc(184);
    load_req = 4'b1000;
    push_ev(186, PH_GREEN,  3, 1'b0);
    push_ev(202, PH_AMBER,  3, 1'b0);
    push_ev(206, PH_ALLRED, 3, 1'b0);
    push_ev(208, PH_GREEN,  0, 1'b0);
    push_ev(224, PH_AMBER,  0, 1'b0);
    push_ev(228, PH_ALLRED, 0, 1'b0);
    push_ev(230, PH_GREEN,  2, 1'b0);
    push_ev(246, PH_AMBER,  2, 1'b0);
    push_ev(250, PH_ALLRED, 2, 1'b0);
    push_ev(252, PH_GREEN,  0, 1'b0);
    push_ev(268, PH_AMBER,  0, 1'b0);
    push_ev(272, PH_ALLRED, 0, 1'b0);
    wait_cyc(186);
    load_req = 4'b0101;

    // Emergency beats load at selection: lowest emergency bit (road 1).
    wait_cyc(272);
    emer_req = 4'b1010;
    load_req = 4'b0001;
    push_ev(274, PH_GREEN, 1, 1'b1);
    push_ev(290, PH_AMBER, 1, 1'b0);
    wait_cyc(274);
    emer_req = 4'b0000;
    load_req = 4'b0000;
    wait_cyc(275);
    chk("t5_ack_pulse", emer_ack, 0);

    // Asynchronous reset mid-amber.
    wait_cyc(291);
    chk("t6_pre_count", countdown, 2);
    chk("t6_pre_phase", phase, PH_AMBER);
    reset = 1'b1;
    #1;
    chk("t6_phase", phase, PH_ALLRED);
    chk("t6_count", countdown, 1);
    chk("t6_bcd", count_bcd, 8'h01);
    chk("t6_red", red, 4'b1111);
    chk("t6_green", green, 4'b0000);
    chk("t6_amber", amber, 4'b0000);
    chk("t6_road", active_road, 3);
    repeat (3) @(negedge clk);
    push_ev(2, PH_GREEN, 0, 1'b0);
    reset = 1'b0;
    wait_cyc(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
